// File: rtl/sram_access_sequencer.sv
// -----------------------------------------------------------------------------
// sram_access_sequencer
//   Sequences one SRAM row access at a time for two requesters. Each access
//   walks precharge -> wordline/bitline development -> (sense, reads only) ->
//   done. Array controls and responses are Moore outputs: next-state and
//   next-output logic feed flops, so every output changes only on a clock edge
//   and lines up with the registered state.
//
//   Optional feature: define SEQ_STATS_EN to add saturating read/write
//   completion counters (rd_count, wr_count).
//
// Ports
//   clk, reset_n                    clock, asynchronous active-low reset
//   reqN_valid/_we/_addr/_wdata     requester N command (N = 0,1)
//   reqN_ready                      one-cycle accept pulse to requester N
//   resp_valid/resp_id/resp_rdata   completion pulse, granted index, read data
//   pre_en, wl_en, wl_addr          precharge enable, wordline enable and row
//   write_en, wdata                 write driver enable and data (writes only)
//   sense_en_n                      sense-amp enable, active-low
//   sa_dout                         sense-amp output, sampled on the last
//                                   sense cycle
//   busy                            high whenever an access is in flight
//   rd_count, wr_count              completion counters (SEQ_STATS_EN only)
// -----------------------------------------------------------------------------
module sram_access_sequencer #(
  parameter int unsigned PRE_CYC = 3,
  parameter int unsigned WL_CYC  = 5,
  parameter int unsigned SA_CYC  = 1,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_wdata,
  output logic              req1_ready,
  output logic              resp_valid,
  output logic              resp_id,
  output logic              resp_rdata,
  output logic              pre_en,
  output logic              wl_en,
  output logic [ADDR_W-1:0] wl_addr,
  output logic              write_en,
  output logic              wdata,
  output logic              sense_en_n,
  input  logic              sa_dout,
  output logic              busy
`ifdef SEQ_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  // Phase counter must hold the longest phase length without wrapping.
  localparam int unsigned MAX_PW = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int unsigned MAX_CYC = (MAX_PW > SA_CYC) ? MAX_PW : SA_CYC;
  localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] WL_LAST  = CNT_W'(WL_CYC - 1);
  localparam logic [CNT_W-1:0] SA_LAST  = CNT_W'(SA_CYC - 1);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_PRE        = 3'd1;
  localparam logic [2:0] ST_WL         = 3'd2;
  localparam logic [2:0] ST_SENSE      = 3'd3;
  // Encoding kept for compatibility; writes complete straight from WL to DONE.
  localparam logic [2:0] ST_WRITE_DONE = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

  // State, phase counter and latched command.
  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              cmd_wdata_q, cmd_wdata_d;
  logic              cmd_id_q, cmd_id_d;
  logic              rdata_q, rdata_d;
  // Index of the requester granted last; reset value 1 favours req0.
  logic              last_q, last_d;

  // Registered outputs.
  logic              ready0_q, ready0_d;
  logic              ready1_q, ready1_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q, resp_id_d;
  logic              resp_rdata_q, resp_rdata_d;
  logic              pre_en_q, pre_en_d;
  logic              wl_en_q, wl_en_d;
  logic [ADDR_W-1:0] wl_addr_q, wl_addr_d;
  logic              write_en_q, write_en_d;
  logic              wdata_out_q, wdata_out_d;
  logic              sense_en_n_q, sense_en_n_d;
  logic              busy_q, busy_d;

  logic              grant;
  logic [CNT_W-1:0]  cnt_inc;

  // Next-state, command latch and next-output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_id_d    = cmd_id_q;
    rdata_d     = rdata_q;
    last_d      = last_q;
    ready0_d    = 1'b0;
    ready1_d    = 1'b0;

    // Both valid: take the one not granted last; otherwise take whichever is valid.
    grant   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    cnt_inc = cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          state_d     = ST_PRE;
          cnt_d       = '0;
          cmd_id_d    = grant;
          last_d      = grant;
          rdata_d     = 1'b0;
          cmd_we_d    = grant ? req1_we    : req0_we;
          cmd_addr_d  = grant ? req1_addr  : req0_addr;
          cmd_wdata_d = grant ? req1_wdata : req0_wdata;
          ready0_d    = ~grant;
          ready1_d    = grant;
        end
      end
      ST_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = ST_WL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WL: begin
        if (cnt_q == WL_LAST) begin
          state_d = cmd_we_q ? ST_DONE : ST_SENSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_SENSE: begin
        if (cnt_q == SA_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          rdata_d = sa_dout;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_WRITE_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs follow the state being entered, so they are valid with it.
    pre_en_d     = (state_d == ST_PRE);
    wl_en_d      = (state_d == ST_WL) || (state_d == ST_SENSE);
    wl_addr_d    = wl_en_d ? cmd_addr_d : '0;
    write_en_d   = (state_d == ST_WL) && cmd_we_d;
    wdata_out_d  = write_en_d ? cmd_wdata_d : 1'b0;
    sense_en_n_d = (state_d != ST_SENSE);
    resp_valid_d = (state_d == ST_DONE);
    resp_id_d    = resp_valid_d ? cmd_id_d : 1'b0;
    resp_rdata_d = (resp_valid_d && !cmd_we_d) ? rdata_d : 1'b0;
    busy_d       = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any in-flight command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= 1'b0;
      cmd_id_q     <= 1'b0;
      rdata_q      <= 1'b0;
      last_q       <= 1'b1;
      ready0_q     <= 1'b0;
      ready1_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_rdata_q <= 1'b0;
      pre_en_q     <= 1'b0;
      wl_en_q      <= 1'b0;
      wl_addr_q    <= '0;
      write_en_q   <= 1'b0;
      wdata_out_q  <= 1'b0;
      sense_en_n_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_id_q     <= cmd_id_d;
      rdata_q      <= rdata_d;
      last_q       <= last_d;
      ready0_q     <= ready0_d;
      ready1_q     <= ready1_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_rdata_q <= resp_rdata_d;
      pre_en_q     <= pre_en_d;
      wl_en_q      <= wl_en_d;
      wl_addr_q    <= wl_addr_d;
      write_en_q   <= write_en_d;
      wdata_out_q  <= wdata_out_d;
      sense_en_n_q <= sense_en_n_d;
      busy_q       <= busy_d;
    end
  end

  assign req0_ready = ready0_q;
  assign req1_ready = ready1_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_rdata = resp_rdata_q;
  assign pre_en     = pre_en_q;
  assign wl_en      = wl_en_q;
  assign wl_addr    = wl_addr_q;
  assign write_en   = write_en_q;
  assign wdata      = wdata_out_q;
  assign sense_en_n = sense_en_n_q;
  assign busy       = busy_q;

`ifdef SEQ_STATS_EN
  // Completion counters, bumped on the edge that leaves DONE, saturating.
  logic [15:0] rd_count_q, wr_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (state_q == ST_DONE) begin
      if (cmd_we_q) begin
        if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
      end else begin
        if (rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: doc/sram_access_sequencer.md
SRAM_ACCESS_SEQUENCER -- requirements
Module: sram_access_sequencer

Interface
REQ-001 Parameters SHALL be: PRE_CYC, default 3, precharge cycles (legal range >=1); WL_CYC, default 5, wordline/bitline-development cycles (>=1); SA_CYC, default 1, sense cycles (>=1); ADDR_W, default 4, row address width.
REQ-002 clk  in  1  clock; all flops rise on posedge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 reqN_valid / reqN_we / reqN_addr / reqN_wdata  in  1/1/ADDR_W/1  requester N command, for N=0,1.
REQ-005 reqN_ready  out  1  one-cycle accept pulse for requester N.
REQ-006 resp_valid / resp_id / resp_rdata  out  1/1/1  completion pulse, granted requester index, read data (0 for writes).
REQ-007 pre_en / wl_en / wl_addr / write_en / wdata  out  1/1/ADDR_W/1/1  array controls, active-high.
REQ-008 sense_en_n  out  1  PMOS sense-amp enable, active-low.
REQ-009 sa_dout  in  1  sense-amp output, valid in the last SENSE cycle.
REQ-010 busy  out  1  high in any state except IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, PRE, WL, SENSE, WRITE_DONE and DONE, and all array outputs SHALL be decoded from the registered state plus the latched command (Moore).
REQ-012 In IDLE with any reqN_valid, the block SHALL accept one command on that edge: latch we, addr and wdata; pulse the granted reqN_ready for exactly that cycle; enter PRE.
REQ-013 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; the pointer resets to favour req0; a single valid is granted regardless of the pointer.
REQ-014 PRE SHALL last PRE_CYC cycles with pre_en=1; wl_en, write_en and sense_en_n stay inactive.
REQ-015 WL SHALL last WL_CYC cycles with wl_en=1 and wl_addr=latched addr; write_en and wdata SHALL be driven throughout WL on writes only.
REQ-016 Reads SHALL go WL->SENSE, which lasts SA_CYC cycles with wl_en=1 and sense_en_n=0; sa_dout SHALL be captured on the final SENSE edge.
REQ-017 Writes SHALL go WL->DONE directly, with sense_en_n=1 throughout.
REQ-018 DONE SHALL last one cycle with resp_valid=1, resp_id=granted index and resp_rdata=captured data (0 for writes), then return to IDLE.
REQ-019 Latency from the accept edge E to the resp_valid cycle SHALL be PRE_CYC+WL_CYC+SA_CYC edges for reads and PRE_CYC+WL_CYC edges for writes.
REQ-020 Invariants: pre_en and (!sense_en_n) never both 1; pre_en and wl_en never both 1; at most one reqN_ready per cycle.
REQ-021 Requests arriving while busy SHALL be ignored (not queued); requesters hold valid until ready.
REQ-022 A new accept SHALL NOT occur in the DONE cycle; the earliest back-to-back accept is the IDLE cycle after DONE.
REQ-023 Phase counters SHALL be sized to hold the largest of PRE_CYC, WL_CYC and SA_CYC without wrap.

Reset
REQ-024 On reset_n=0 (asynchronous, including mid-operation): state=IDLE; pre_en=wl_en=write_en=wdata=0; wl_addr=0; sense_en_n=1; reqN_ready=0; resp_valid=resp_id=resp_rdata=0; busy=0; RR pointer favours req0.
REQ-025 A command in flight at reset SHALL be dropped with no response.

Configuration
REQ-026 With macro SEQ_STATS_EN defined, outputs rd_count[15:0] and wr_count[15:0] SHALL exist, each incrementing in DONE for its operation type, saturating at 16'hFFFF, and reset to 0.
REQ-027 Without SEQ_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Default parameters, req0 read addr=5, sa_dout=1 -> pre_en high 3 cycles, wl_en high 6 cycles with wl_addr=5, sense_en_n low 1 cycle, resp_valid 9 edges after accept, resp_rdata=1, resp_id=0.
REQ-029 req1 write addr=2 wdata=1 -> write_en and wl_en high 5 cycles, sense_en_n stays 1, resp_valid 8 edges after accept, resp_id=1, resp_rdata=0.
REQ-030 req0 and req1 held valid for 4 commands -> grants alternate 0,1,0,1; each accept falls in the IDLE cycle after the previous DONE.
REQ-031 reset_n pulsed low during WL -> all outputs reach reset values immediately, no resp_valid follows, and the next request is accepted normally.
REQ-032 Random traffic over 10k cycles -> REQ-020 invariants hold every cycle; with SEQ_STATS_EN, rd_count+wr_count equals the resp_valid count.
